// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types, mux encodings and the sign-extension helper.
package lc3_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOT   = 2'b10,
    ALU_PASSA = 2'b11
  } aluk_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_BUS  = 2'b01,
    PC_ADDR = 2'b10,
    PC_HOLD = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'b00,
    A2_OFF6  = 2'b01,
    A2_OFF9  = 2'b10,
    A2_OFF11 = 2'b11
  } addr2mux_e;

  // Replicate bit msb of v into every higher bit position.
  function automatic word_t sext(input word_t v, input logic [3:0] msb);
    word_t r;
    for (int i = 0; i < 16; i++) begin
      r[i] = (4'(i) > msb) ? v[msb] : v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 register file: one synchronous write port, two combinational read ports.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       we_i,
  input  logic [2:0] waddr_i,
  input  word_t      wdata_i,
  input  logic [2:0] raddr1_i,
  input  logic [2:0] raddr2_i,
  output word_t      rdata1_o,
  output word_t      rdata2_o
);

  word_t regs_q [8];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/lc3_datapath.sv
// LC-3 datapath: PC/MAR/MDR/IR/NZP/BEN/LED state, internal bus, ALU and address adder.
module lc3_datapath
  import lc3_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        LD_IR,
  input  logic        LD_BEN,
  input  logic        LD_CC,
  input  logic        LD_REG,
  input  logic        LD_PC,
  input  logic        LD_LED,
  input  logic        GatePC,
  input  logic        GateMDR,
  input  logic        GateALU,
  input  logic        GateMARMUX,
  input  logic [1:0]  PCMUX,
  input  logic        DRMUX,
  input  logic        SR1MUX,
  input  logic        SR2MUX,
  input  logic        ADDR1MUX,
  input  logic [1:0]  ADDR2MUX,
  input  logic [1:0]  ALUK,
  input  logic        Mem_OE,
  input  logic [15:0] Data_From_SRAM,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic [11:0] LED,
  output logic [3:0]  Opcode,
  output logic        IR_5,
  output logic        IR_11,
  output logic        BEN
);

  word_t       pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic [11:0] led_q, led_d;
  logic [2:0]  nzp_q, nzp_d, nzp_bus;
  logic        ben_q, ben_d;

  word_t       bus, alu_out, alu_b, addr1, addr2, addr_sum, sr1_out, sr2_out;
  logic [2:0]  sr1_idx, dr_idx;

  assign sr1_idx = SR1MUX ? ir_q[11:9] : ir_q[8:6];
  assign dr_idx  = DRMUX ? 3'd7 : ir_q[11:9];

  lc3_regfile u_regfile (
    .Clk      (Clk),
    .Reset    (Reset),
    .we_i     (LD_REG),
    .waddr_i  (dr_idx),
    .wdata_i  (bus),
    .raddr1_i (sr1_idx),
    .raddr2_i (ir_q[2:0]),
    .rdata1_o (sr1_out),
    .rdata2_o (sr2_out)
  );

  // Operand muxes, ALU, address adder and the prioritised bus.
  always_comb begin
    alu_b = SR2MUX ? sext(ir_q, 4'd4) : sr2_out;
    case (aluk_e'(ALUK))
      ALU_ADD: alu_out = sr1_out + alu_b;
      ALU_AND: alu_out = sr1_out & alu_b;
      ALU_NOT: alu_out = ~sr1_out;
      default: alu_out = sr1_out;
    endcase

    addr1 = ADDR1MUX ? sr1_out : pc_q;
    case (addr2mux_e'(ADDR2MUX))
      A2_ZERO: addr2 = '0;
      A2_OFF6: addr2 = sext(ir_q, 4'd5);
      A2_OFF9: addr2 = sext(ir_q, 4'd8);
      default: addr2 = sext(ir_q, 4'd10);
    endcase
    addr_sum = addr1 + addr2;

    if (GatePC)          bus = pc_q;
    else if (GateMDR)    bus = mdr_q;
    else if (GateALU)    bus = alu_out;
    else if (GateMARMUX) bus = addr_sum;
    else                 bus = '0;

    if (bus[15])         nzp_bus = 3'b100;
    else if (bus == '0)  nzp_bus = 3'b010;
    else                 nzp_bus = 3'b001;
  end

  // Next-state selection; every register holds unless its load enable is set.
  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    ir_d  = ir_q;
    led_d = led_q;
    nzp_d = nzp_q;
    ben_d = ben_q;

    if (LD_PC) begin
      case (pcmux_e'(PCMUX))
        PC_INC:  pc_d = pc_q + 16'd1;
        PC_BUS:  pc_d = bus;
        PC_ADDR: pc_d = addr_sum;
        default: pc_d = pc_q;
      endcase
    end
    if (LD_MAR) mar_d = bus;
    if (LD_MDR) mdr_d = Mem_OE ? bus : Data_From_SRAM;
    if (LD_IR)  ir_d  = bus;
    if (LD_LED) led_d = ir_q[11:0];
    if (LD_CC)  nzp_d = nzp_bus;
    if (LD_BEN) ben_d = (ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) | (ir_q[9] & nzp_q[0]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      led_q <= '0;
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      led_q <= led_d;
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

  assign MAR    = mar_q;
  assign MDR    = mdr_q;
  assign IR     = ir_q;
  assign PC     = pc_q;
  assign LED    = led_q;
  assign BEN    = ben_q;
  assign Opcode = ir_q[15:12];
  assign IR_5   = ir_q[5];
  assign IR_11  = ir_q[11];

endmodule

// File: tb/tb_lc3_datapath.sv
// Directed plus randomised control-word bench for lc3_datapath against an architectural model.
module tb_lc3_datapath;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE;
  logic [15:0] Data_From_SRAM;
  logic [15:0] MAR, MDR, IR, PC;
  logic [11:0] LED;
  logic [3:0]  Opcode;
  logic        IR_5, IR_11, BEN;

  always #5 Clk = ~Clk;

  lc3_datapath dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE),
    .Data_From_SRAM(Data_From_SRAM),
    .MAR(MAR), .MDR(MDR), .IR(IR), .PC(PC), .LED(LED),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN)
  );

  int checks = 0;
  int failures = 0;

  // Architectural state of the model.
  logic [15:0] m_r [8];
  logic [15:0] m_pc, m_mar, m_mdr, m_ir;
  logic [11:0] m_led;
  logic        m_n, m_z, m_p, m_ben;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("MAR", MAR, m_mar);
    chk("MDR", MDR, m_mdr);
    chk("IR", IR, m_ir);
    chk("PC", PC, m_pc);
    chk("LED", 16'(LED), 16'(m_led));
    chk("BEN", 16'(BEN), 16'(m_ben));
    chk("Opcode", 16'(Opcode), 16'(m_ir[15:12]));
    chk("IR_5", 16'(IR_5), 16'(m_ir[5]));
    chk("IR_11", 16'(IR_11), 16'(m_ir[11]));
  endtask

  // One clock: evaluate the control word on the model, clock both, then compare.
  task automatic tick();
    logic [15:0] sr1, sr2v, b, alu, a1, a2, bus, n_pc, n_mdr;
    logic [2:0]  dr;
    logic        n_ben;
    sr1  = SR1MUX ? m_r[m_ir[11:9]] : m_r[m_ir[8:6]];
    sr2v = m_r[m_ir[2:0]];
    b    = SR2MUX ? {{11{m_ir[4]}}, m_ir[4:0]} : sr2v;
    case (ALUK)
      2'b00:   alu = sr1 + b;
      2'b01:   alu = sr1 & b;
      2'b10:   alu = ~sr1;
      default: alu = sr1;
    endcase
    a1 = ADDR1MUX ? sr1 : m_pc;
    case (ADDR2MUX)
      2'b00:   a2 = 16'h0000;
      2'b01:   a2 = {{10{m_ir[5]}}, m_ir[5:0]};
      2'b10:   a2 = {{7{m_ir[8]}}, m_ir[8:0]};
      default: a2 = {{5{m_ir[10]}}, m_ir[10:0]};
    endcase
    bus = GatePC ? m_pc : GateMDR ? m_mdr : GateALU ? alu : GateMARMUX ? a1 + a2 : 16'h0000;
    case (PCMUX)
      2'b00:   n_pc = m_pc + 16'd1;
      2'b01:   n_pc = bus;
      2'b10:   n_pc = a1 + a2;
      default: n_pc = m_pc;
    endcase
    n_mdr = Mem_OE ? bus : Data_From_SRAM;
    n_ben = (m_ir[11] & m_n) | (m_ir[10] & m_z) | (m_ir[9] & m_p);
    dr    = DRMUX ? 3'd7 : m_ir[11:9];
    @(posedge Clk);
    #1;
    if (Reset) begin
      foreach (m_r[i]) m_r[i] = 16'h0000;
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_led = 0;
      m_n = 0; m_z = 1; m_p = 0; m_ben = 0;
    end else begin
      if (LD_LED) m_led = m_ir[11:0];
      if (LD_BEN) m_ben = n_ben;
      if (LD_CC) begin
        m_n = bus[15];
        m_z = (bus == 16'h0000);
        m_p = !bus[15] && (bus != 16'h0000);
      end
      if (LD_REG) m_r[dr] = bus;
      if (LD_PC)  m_pc = n_pc;
      if (LD_MAR) m_mar = bus;
      if (LD_MDR) m_mdr = n_mdr;
      if (LD_IR)  m_ir = bus;
    end
    compare_all();
  endtask

  task automatic clr();
    Reset = 0;
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX} = '0;
    PCMUX = 2'b11; ADDR2MUX = 0; ALUK = 0;
    Mem_OE = 1; Data_From_SRAM = 0;
  endtask

  task automatic mem_to_mdr(input logic [15:0] d);
    clr(); LD_MDR = 1; Mem_OE = 0; Data_From_SRAM = d; tick();
  endtask

  task automatic load_ir(input logic [15:0] d);
    mem_to_mdr(d);
    clr(); GateMDR = 1; LD_IR = 1; tick();
  endtask

  task automatic load_pc(input logic [15:0] d);
    mem_to_mdr(d);
    clr(); GateMDR = 1; PCMUX = 2'b01; LD_PC = 1; tick();
  endtask

  // Copy the SR1-selected register onto MAR through the ALU pass path.
  task automatic peek_reg(input logic sel);
    clr(); GateALU = 1; ALUK = 2'b11; SR1MUX = sel; LD_MAR = 1; tick();
  endtask

  initial begin
    foreach (m_r[i]) m_r[i] = 16'hxxxx;
    clr();
    Reset = 1;
    tick(); tick();
    chk("reset_PC", PC, 16'h0000);
    chk("reset_BEN", 16'(BEN), 16'h0000);

    clr(); GatePC = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 2'b00;
    repeat (3) tick();
    chk("fetch_MAR", MAR, 16'h0002);
    chk("fetch_PC", PC, 16'h0003);

    mem_to_mdr(16'h1283);
    chk("mdr_read", MDR, 16'h1283);
    clr(); GateMDR = 1; LD_IR = 1; tick();
    chk("ir_load", IR, 16'h1283);
    chk("opcode", 16'(Opcode), 16'h0001);
    chk("ir5_ir11", {14'b0, IR_5, IR_11}, 16'h0000);

    load_ir(16'h0400);
    mem_to_mdr(16'h0002);
    clr(); GateMDR = 1; LD_REG = 1; tick();
    load_ir(16'h12BD);
    clr(); SR2MUX = 1; GateALU = 1; ALUK = 2'b00; LD_REG = 1; LD_CC = 1; tick();
    peek_reg(1'b1);
    chk("add_imm_R1", MAR, 16'hFFFF);
    load_ir(16'h0805);
    clr(); LD_BEN = 1; tick();
    chk("ben_n", 16'(BEN), 16'h0001);

    load_pc(16'h3000);
    load_ir(16'h4802);
    clr(); ADDR1MUX = 0; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1;
    GatePC = 1; DRMUX = 1; LD_REG = 1; tick();
    chk("jsr_PC", PC, 16'h3002);
    load_ir(16'h0FC0);
    peek_reg(1'b0);
    chk("jsr_R7", MAR, 16'h3000);
    clr(); LD_LED = 1; tick();
    chk("led", 16'(LED), 16'h0FC0);

    load_pc(16'hFFFF);
    clr(); PCMUX = 2'b00; LD_PC = 1; tick();
    chk("pc_wrap", PC, 16'h0000);

    clr(); Reset = 1; LD_PC = 1; LD_REG = 1; GatePC = 1; PCMUX = 2'b00; DRMUX = 1; tick();
    chk("rst_PC", PC, 16'h0000);
    chk("rst_IR", IR, 16'h0000);
    chk("rst_MAR", MAR, 16'h0000);
    load_ir(16'h0FC0);
    peek_reg(1'b0);
    chk("rst_R7", MAR, 16'h0000);
    load_ir(16'h0400);
    clr(); LD_BEN = 1; tick();
    chk("rst_nzp_z", 16'(BEN), 16'h0001);

    // Random control words exercise gate priority and same-cycle interactions.
    foreach (m_r[i]) m_r[i] = 16'h0000;
    clr(); Reset = 1; tick();
    for (int k = 0; k < 400; k++) begin
      Reset = ($urandom_range(0, 63) == 0);
      {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = 8'($urandom);
      {GatePC, GateMDR, GateALU, GateMARMUX} = 4'($urandom);
      {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE} = 5'($urandom);
      PCMUX = 2'($urandom); ADDR2MUX = 2'($urandom); ALUK = 2'($urandom);
      Data_From_SRAM = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
